dcache_wb_ctrl: RTL

Write-back, write-allocate, direct-mapped data cache controller that answers the pipeline's memory-stage requests. It returns `ReadDataM` on hits in the same cycle and raises `Cache_Stall` on misses. Missed lines are fetched from main memory over a 128-bit request/acknowledge port; dirty victims are written back first. It sits between the memory stage of the datapath and the main-memory model, in the slot of the existing data-memory instance.

---
 rtl/dcache_wb_ctrl_pkg.sv | 19 +
 rtl/dcache_wb_ctrl_if.sv | 22 ++
 rtl/dcache_array.sv | 62 ++++++
 rtl/dcache_wb_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/dcache_wb_ctrl_pkg.sv
// Shared types and constants for the write-back data cache controller.
package dcache_wb_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RF   = 2'd2
    } cacheState_t;

    localparam int LINE_W       = 128;
    localparam int WORD_SEL_LSB = 2;
    localparam int OFFSET_W     = 4;

    // Address bits left for the tag once the byte offset and index are removed.
    function automatic int tagWidth(input int lines);
        return 32 - OFFSET_W - $clog2(lines);
    endfunction

endpackage

// File: rtl/dcache_wb_ctrl_if.sv
// Line-wide request/acknowledge port between the data cache and main memory.
interface dcache_wb_ctrl_if;
    import dcache_wb_ctrl_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [LINE_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/dcache_array.sv
// Direct-mapped line storage: valid/dirty/tag/data with one async read port
// and one sync write port (single word or whole line).
module dcache_array
    import dcache_wb_ctrl_pkg::*;
#(
    parameter int LINES = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rdIdx,
    output logic              rdValid,
    output logic              rdDirty,
    output logic [TAG_W-1:0]  rdTag,
    output logic [LINE_W-1:0] rdLine,
    input  logic              wrEn,
    input  logic              wrLineMode,
    input  logic [IDX_W-1:0]  wrIdx,
    input  logic [1:0]        wrWord,
    input  logic [31:0]       wrWordData,
    input  logic [LINE_W-1:0] wrLine,
    input  logic [TAG_W-1:0]  wrTag
);

    logic [LINES-1:0]  valid;
    logic [LINES-1:0]  dirty;
    logic [TAG_W-1:0]  tagArr  [LINES];
    logic [LINE_W-1:0] dataArr [LINES];

    assign rdValid = valid[rdIdx];
    assign rdDirty = dirty[rdIdx];
    assign rdTag   = tagArr[rdIdx];
    assign rdLine  = dataArr[rdIdx];

    // A refill leaves the line clean; a word store marks it dirty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
            dirty <= '0;
        end else if (wrEn) begin
            if (wrLineMode) begin
                valid[wrIdx] <= 1'b1;
                dirty[wrIdx] <= 1'b0;
            end else begin
                dirty[wrIdx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            if (wrLineMode) begin
                dataArr[wrIdx] <= wrLine;
                tagArr[wrIdx]  <= wrTag;
            end else begin
                dataArr[wrIdx][{wrWord, 5'b0} +: 32] <= wrWordData;
            end
        end
    end

endmodule

// File: rtl/dcache_wb_ctrl.sv
// Write-back, write-allocate direct-mapped data cache controller.
//   state | meaning
//   IDLE  | serve hits; on a miss pick writeback or refill
//   WB    | write the dirty victim line to memory, wait for ack
//   RF    | read the requested line from memory, wait for ack
module dcache_wb_ctrl
    import dcache_wb_ctrl_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   MemtoRegM,
    input  logic                   MemWriteM,
    input  logic [31:0]            ALUOutM,
    input  logic [31:0]            WriteDataM,
    output logic [31:0]            ReadDataM,
    output logic                   Cache_Stall,
    dcache_wb_ctrl_if.master       memBus,
    output logic [15:0]            hit_count,
    output logic [15:0]            miss_count
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = tagWidth(LINES);

    cacheState_t state, stateNext;

    logic [1:0]        reqWord;
    logic [IDX_W-1:0]  reqIdx;
    logic [TAG_W-1:0]  reqTag;
    logic              req, isLoad, isStore, hit;
    logic              rdValid, rdDirty;
    logic [TAG_W-1:0]  rdTag;
    logic [LINE_W-1:0] rdLine;
    logic              wrEn, wrLineMode;
    logic              stall, hitInc, missInc;
    logic              unusedByteOffset;

    assign reqWord          = ALUOutM[WORD_SEL_LSB +: 2];
    assign reqIdx           = ALUOutM[OFFSET_W +: IDX_W];
    assign reqTag           = ALUOutM[OFFSET_W + IDX_W +: TAG_W];
    assign unusedByteOffset = ^ALUOutM[WORD_SEL_LSB-1:0];

    assign isStore = MemWriteM;
    assign isLoad  = MemtoRegM & ~MemWriteM;
    assign req     = MemtoRegM | MemWriteM;
    assign hit     = req & rdValid & (rdTag == reqTag);

    dcache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk        (clk),
        .reset      (reset),
        .rdIdx      (reqIdx),
        .rdValid    (rdValid),
        .rdDirty    (rdDirty),
        .rdTag      (rdTag),
        .rdLine     (rdLine),
        .wrEn       (wrEn),
        .wrLineMode (wrLineMode),
        .wrIdx      (reqIdx),
        .wrWord     (reqWord),
        .wrWordData (WriteDataM),
        .wrLine     (memBus.mem_rdata),
        .wrTag      (reqTag)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext        = state;
        stall            = 1'b0;
        hitInc           = 1'b0;
        missInc          = 1'b0;
        wrEn             = 1'b0;
        wrLineMode       = 1'b0;
        ReadDataM        = '0;
        memBus.mem_req   = 1'b0;
        memBus.mem_we    = 1'b0;
        memBus.mem_addr  = '0;
        memBus.mem_wdata = '0;
        unique case (state)
            IDLE: begin
                if (hit) begin
                    hitInc = 1'b1;
                    if (isStore) wrEn      = 1'b1;
                    if (isLoad)  ReadDataM = rdLine[{reqWord, 5'b0} +: 32];
                end else if (req) begin
                    stall     = 1'b1;
                    missInc   = 1'b1;
                    stateNext = (rdValid && rdDirty) ? WB : RF;
                end
            end
            WB: begin
                stall            = 1'b1;
                memBus.mem_req   = 1'b1;
                memBus.mem_we    = 1'b1;
                memBus.mem_addr  = {rdTag, reqIdx, {OFFSET_W{1'b0}}};
                memBus.mem_wdata = rdLine;
                if (memBus.mem_ack) stateNext = RF;
            end
            RF: begin
                stall           = 1'b1;
                memBus.mem_req  = 1'b1;
                memBus.mem_addr = {reqTag, reqIdx, {OFFSET_W{1'b0}}};
                if (memBus.mem_ack) begin
                    wrEn       = 1'b1;
                    wrLineMode = 1'b1;
                    stateNext  = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // The pipeline must see no stall while reset holds the cache empty.
    assign Cache_Stall = stall & reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hitInc)  hit_count  <= hit_count + 16'd1;
            if (missInc) miss_count <= miss_count + 16'd1;
        end
    end

endmodule
